addsub_serial_ctrl: RTL and testbench
=====================================

# addsub_serial_ctrl

Sequencing controller that performs a wide add or subtract by time-multiplexing a single 4-bit adder-subtractor slice, one nibble per clock, LSB nibble first. It accepts one operand pair per transaction over a valid/ready handshake. It chains the carry between nibbles in a register and returns the full-width result, carry-out and signed overflow over a second valid/ready handshake. It sits between an operand source (register file or test driver) and any consumer of wide arithmetic results.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports (reset is asynchronous and active-high):
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair and op are valid
- in_ready  out  1  controller can accept a transaction
- op  in  1  0 = add (a+b), 1 = subtract (a-b); same polarity as the slice's cin
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  result registers hold a completed result
- out_ready  in  1  consumer accepts the result
- s  out  W  result, modulo 2^W
- cout  out  1  carry out of the MSB nibble; for subtract, 1 = no borrow
- ovf  out  1  two's-complement overflow
- busy  out  1  transaction in progress (RUN or DONE)

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a, b, op into operand registers, set idx=0 and carry=op, go to RUN.
- RUN: on each cycle, the slice computes nibble idx:
  - inputs are a[idx], b[idx] XOR {4{op}}, and carry;
  - s[idx] is written and carry is updated to the slice carry-out;
  - when idx=NIBBLES-1: latch cout=carry-out and compute ovf, then go to DONE; otherwise idx is incremented.
- ovf = (a[W-1] == beff[W-1]) && (s[W-1] != a[W-1]), where beff = b XOR {W{op}}.
- DONE:
  - out_valid=1, and s, cout, ovf are held stable.
  - On out_ready: return to IDLE.
  - in_valid is ignored; there is no same-cycle restart.
- in_ready and out_valid are decoded from state only; neither depends combinationally on in_valid or out_ready.
- busy = (state != IDLE).
- Operand inputs are sampled only at acceptance; later changes to a, b or op do not affect the transaction in flight.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, ovf=0, idx=0, carry=0.
- Assertion of rst mid-transaction aborts the operation immediately. The result is lost and no out_valid is produced.
- Accept edge T (in_valid && in_ready): RUN occupies edges T+1 .. T+NIBBLES, and out_valid is high from the cycle after edge T+NIBBLES.
- Latency from acceptance to out_valid is therefore NIBBLES+1 cycles. With NIBBLES=1, the single RUN edge goes straight to DONE.
- Release edge R (out_valid && out_ready): in_ready=1 from the cycle after R. Minimum issue interval is NIBBLES+2 cycles.
- During RUN, s holds partial nibbles; its value is defined only while out_valid=1.
- With out_ready held low, DONE persists indefinitely and all outputs stay constant.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, RUN, DONE);
  - OP_ADD=1'b0 and OP_SUB=1'b1;
  - NIBBLE_W=4.
- One sub-module, addsub_nibble: a purely combinational 4-bit add with ports a[3:0], b[3:0], ci, s[3:0], co.
  - B inversion is done by the controller, not inside the slice, because ci must carry the chained carry rather than the op bit.
- idx width is clog2(NIBBLES), with a minimum of 1 bit.

## Test plan
With NIBBLES=4:
- Add 0x1234 + 0x0FCD -> s=0x2201, cout=0, ovf=0; out_valid exactly 5 cycles after acceptance.
- Subtract 0x0005 - 0x0007 -> s=0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x8000 - 0x0001 -> s=0x7FFF, cout=1, ovf=1.
- Add 0x7FFF + 0x0001 -> s=0x8000, ovf=1, cout=0. Add 0xFFFF + 0x0001 -> s=0x0000, cout=1, ovf=0, checking the carry ripple through all four nibbles.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid with in_valid=1 and new operands.
  - Required: s, cout, ovf stable, in_ready=0, and the second transaction is not accepted until the cycle after release.
- Reset abort: assert rst at cycle 2 of RUN.
  - Required: out_valid never asserts, all outputs are at reset values, and a subsequent 0x0001 + 0x0001 yields s=0x0002.
- Random: 1000 back-to-back transactions against a reference model computing a±b mod 2^16 plus carry/overflow, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/addsub_serial_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
// Holds the FSM state encoding, op codes and the slice width.
package addsub_serial_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Two's-complement overflow: same-sign operands giving a result of the other sign.
   function automatic logic signed_ovf(input logic a_msb, input logic beff_msb,
                                       input logic s_msb);
      return (a_msb == beff_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_serial_ctrl_nibble.sv
// Purely combinational 4-bit adder slice; operand inversion for subtract
// is the caller's job so ci can carry the chained carry.
module addsub_nibble
   import addsub_serial_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic [NIBBLE_W:0] sum;

   assign sum     = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
   assign {co, s} = sum;

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Wide add/subtract by reusing one 4-bit slice per clock, LSB nibble first.
// Handshake: a side transfers on the rising edge where valid && ready are both high.
module addsub_serial_ctrl
   import addsub_serial_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        op,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] s,
   output logic                        cout,
   output logic                        ovf,
   output logic                        busy,
   output state_e                      dbg_state
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_e state_q, state_d;

   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     s_q, s_d;
   logic             op_q, op_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
   logic                nib_co;
   logic                last;
   logic                accept;
   int                  base;

   assign last   = (idx_q == IDX_LAST);
   assign accept = (state_q == ST_IDLE) && in_valid;
   assign base   = int'(idx_q) * NIBBLE_W;

   assign nib_a = a_q[base +: NIBBLE_W];
   assign nib_b = b_q[base +: NIBBLE_W] ^ {NIBBLE_W{op_q}};

   addsub_nibble u_slice (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (nib_s),
      .co (nib_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (last)      state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      dbg_state = state_q;
   end

   // Operands are frozen at acceptance; the result registers only move during RUN.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      if (accept) begin
         a_d     = a;
         b_d     = b;
         op_d    = op;
         idx_d   = '0;
         carry_d = op;
      end else if (state_q == ST_RUN) begin
         s_d[base +: NIBBLE_W] = nib_s;
         carry_d               = nib_co;
         if (last) begin
            cout_d = nib_co;
            ovf_d  = signed_ovf(a_q[W-1], b_q[W-1] ^ op_q, nib_s[NIBBLE_W-1]);
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Bench for addsub_serial_ctrl (NIBBLES=4): directed corner cases, backpressure,
// reset abort and random transactions against an integer-arithmetic model.
module tb_addsub_serial_ctrl;
   import addsub_serial_ctrl_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;
   logic         busy;
   state_e       dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [W+1:0] exp_q[$];
   logic [W+1:0] cur_exp;

   addsub_serial_ctrl #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic, packed as {ovf, cout, s}.
   function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      int           sa, sb, r, ux, uy;
      logic         c, v;
      logic [W-1:0] res;
      sa = $signed(x);
      sb = $signed(y);
      ux = int'(x);
      uy = int'(y);
      if (o) begin
         r = sa - sb;
         c = (ux >= uy);
      end else begin
         r = sa + sb;
         c = (ux + uy) > 65535;
      end
      v   = (r > 32767) || (r < -32768);
      res = W'(r);
      return {v, c, res};
   endfunction

   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      int t;
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", (t < 20) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      op = 1'($urandom);
      exp_q.push_back(model(o, x, y));
   endtask

   task automatic wait_result();
      int lat;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, NIB + 1);
      check("out_valid", out_valid, 1);
      cur_exp = exp_q.pop_front();
      check("s", s, cur_exp[W-1:0]);
      check("cout", cout, cur_exp[W]);
      check("ovf", ovf, cur_exp[W+1]);
   endtask

   task automatic release_res();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("rel_out_valid", out_valid, 0);
      check("rel_in_ready", in_ready, 1);
   endtask

   task automatic one_txn(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      issue(o, x, y);
      wait_result();
      release_res();
   endtask

   initial begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_s", s, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rst = 1'b0;
      @(negedge clk);

      one_txn(OP_ADD, 16'h1234, 16'h0FCD);
      one_txn(OP_SUB, 16'h0005, 16'h0007);
      one_txn(OP_SUB, 16'h8000, 16'h0001);
      one_txn(OP_ADD, 16'h7FFF, 16'h0001);
      one_txn(OP_ADD, 16'hFFFF, 16'h0001);
      check("dir_ffff_s", s, 16'h0000);

      // Backpressure with a new request waiting.
      issue(OP_ADD, 16'hABCD, 16'h1111);
      wait_result();
      in_valid = 1'b1;
      op = OP_SUB;
      a = 16'h4000;
      b = 16'h0123;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_s", s, cur_exp[W-1:0]);
         check("bp_cout", cout, cur_exp[W]);
         check("bp_ovf", ovf, cur_exp[W+1]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_rel_busy", busy, 0);
      check("bp_rel_in_ready", in_ready, 1);
      @(negedge clk);
      check("bp_second_busy", busy, 1);
      in_valid = 1'b0;
      exp_q.push_back(model(OP_SUB, 16'h4000, 16'h0123));
      wait_result();
      release_res();

      // Reset during the second RUN cycle.
      issue(OP_ADD, 16'h1234, 16'h5678);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_s", s, 0);
      check("abort_cout", cout, 0);
      check("abort_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("abort_no_valid", out_valid, 0);
      end
      one_txn(OP_ADD, 16'h0001, 16'h0001);

      for (int i = 0; i < 1000; i++) begin
         logic         o;
         logic [W-1:0] x, y;
         int           hold;
         o = 1'($urandom_range(0, 1));
         x = W'($urandom);
         y = W'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(o, x, y);
         wait_result();
         hold = $urandom_range(0, 3);
         repeat (hold) begin
            @(negedge clk);
            check("hold_s", s, cur_exp[W-1:0]);
         end
         release_res();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
